// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester/response handshake bundle between two clients and the ALU arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int NOPS  = 7
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic [15:0]      ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [OPW-1:0] OP_NOP   = '0;
    localparam logic [OPW-1:0] OP_LIMIT = OPW'(NOPS);

    state_t           state, state_n;
    logic             prio;
    logic             grant;
    logic             rsp0_valid_q, rsp1_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;

    logic             any_valid;
    logic             winner;
    logic             accept;
    logic             rsp_hs;

    // Requester prio wins only a tie; a lone valid always wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            winner = prio;
        else
            winner = bus.req1_valid;
        accept = (state == IDLE) && any_valid;
        rsp_hs = (state == RESP) && (grant ? bus.rsp1_ready : bus.rsp0_ready);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = EXEC;
            EXEC:    state_n = RESP;
            RESP:    if (rsp_hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = accept && !winner;
        bus.req1_ready = accept && winner;
        bus.rsp0_valid = rsp0_valid_q;
        bus.rsp1_valid = rsp1_valid_q;
        bus.rsp_data   = rsp_data_q;
        bus.rsp_err    = rsp_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= OP_NOP;
            grant        <= 1'b0;
            prio         <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            ops_done     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a  <= winner ? bus.req1_a  : bus.req0_a;
                        alu_b  <= winner ? bus.req1_b  : bus.req0_b;
                        alu_op <= winner ? bus.req1_op : bus.req0_op;
                        grant  <= winner;
                    end
                end
                EXEC: begin
                    // NOP and illegal opcodes never expose whatever the ALU drives.
                    if (alu_op == OP_NOP) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
                    end else if (alu_op >= OP_LIMIT) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        rsp_data_q <= alu_out;
                        rsp_err_q  <= 1'b0;
                    end
                    alu_op       <= OP_NOP;
                    rsp0_valid_q <= !grant;
                    rsp1_valid_q <= grant;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        ops_done     <= ops_done + 16'd1;
                        prio         <= ~grant;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
